reg_status_table: RTL

- Register status table (RST) for the dynamically scheduled MIPS core.
- Sits directly downstream of the 5-to-32 write-enable decoder and consumes its one-hot output. Each asserted bit marks the destination register as pending on a new producer tag.
- Entries clear when the common data bus (CDB) broadcasts the matching tag.
- Dispatch reads two source registers and gets each one's pending status and producer tag.

---
 rtl/reg_status_table.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_status_table.sv
// reg_status_table: per-register pending/tag scoreboard for the dynamically
// scheduled MIPS core. Dispatch marks destinations busy on a producer tag,
// CDB broadcasts clear matching entries, and two read ports return each
// source register's pending status with a same-cycle CDB bypass.
module reg_status_table #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      wen_onehot,
   input  logic [TAG_W-1:0] wtag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic             flush,
   input  logic [4:0]       rs_addr,
   input  logic [4:0]       rt_addr,
   output logic             rs_busy,
   output logic [TAG_W-1:0] rs_tag,
   output logic             rt_busy,
   output logic [TAG_W-1:0] rt_tag,
   output logic [5:0]       pending_cnt,
   output logic             err_onehot
);

   // Table state and its next-state image, one element per architectural register.
   logic             busy_reg  [32];
   logic [TAG_W-1:0] tag_reg   [32];
   logic             busy_next [32];
   logic [TAG_W-1:0] tag_next  [32];

   logic [5:0] cnt_next;
   logic       err_next;
   logic       rs_cdb_hit;
   logic       rt_cdb_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_entry
         if (gi == 0) begin : g_zero
            // $zero never becomes pending, whatever the decoder drives on bit 0.
            always_comb begin
               busy_next[gi] = 1'b0;
               tag_next[gi]  = '0;
            end
         end else begin : g_reg
            // Priority: clear-all, then new producer, then completion, else hold.
            // A new producer overrides a same-cycle completion of the old tag.
            always_comb begin
               busy_next[gi] = busy_reg[gi];
               tag_next[gi]  = tag_reg[gi];
               if (rst || flush) begin
                  busy_next[gi] = 1'b0;
                  tag_next[gi]  = '0;
               end else if (wen_onehot[gi]) begin
                  busy_next[gi] = 1'b1;
                  tag_next[gi]  = wtag;
               end else if (cdb_valid && busy_reg[gi] && (tag_reg[gi] == cdb_tag)) begin
                  busy_next[gi] = 1'b0;
                  tag_next[gi]  = '0;
               end
            end
         end
      end
   endgenerate

   // Popcount of the next-state busy bits so the count lines up with the table.
   always_comb begin
      cnt_next = '0;
      for (int i = 1; i < 32; i++) begin
         cnt_next = cnt_next + {5'd0, busy_next[i]};
      end
   end

   // More than one decoder bit set (bit 0 included) is flagged as illegal.
   always_comb begin
      err_next = ($countones(wen_onehot) > 1);
   end

   // Table, counter and error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            busy_reg[i] <= 1'b0;
            tag_reg[i]  <= '0;
         end
         pending_cnt <= '0;
         err_onehot  <= 1'b0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            busy_reg[i] <= busy_next[i];
            tag_reg[i]  <= tag_next[i];
         end
         pending_cnt <= cnt_next;
         err_onehot  <= err_next;
      end
   end

   // Read ports see pre-edge state; a completing CDB tag bypasses to not-busy.
   // Entry 0 is held clear in state, so address 0 always reads idle.
   always_comb begin
      rs_cdb_hit = cdb_valid && (tag_reg[rs_addr] == cdb_tag);
      rt_cdb_hit = cdb_valid && (tag_reg[rt_addr] == cdb_tag);
      rs_busy    = busy_reg[rs_addr] && !rs_cdb_hit;
      rt_busy    = busy_reg[rt_addr] && !rt_cdb_hit;
      rs_tag     = rs_busy ? tag_reg[rs_addr] : '0;
      rt_tag     = rt_busy ? tag_reg[rt_addr] : '0;
   end

endmodule
